mvau_weight_ctrl: RTL

MVAU_WEIGHT_CTRL -- requirements
Module: mvau_weight_ctrl

---
 rtl/mvau_weight_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mvau_weight_ctrl.sv
// Weight streamer for an MVAU: reads the weight memory num_reps times in address
// order and feeds the PE datapath through a 3-entry skid FIFO with valid/ready.
module mvau_weight_ctrl #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4,
  parameter int REP_BW       = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [REP_BW-1:0]       num_reps,
  output logic                    busy,
  output logic                    done,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  input  logic [SIMD*TW-1:0]      wmem_in,
  output logic [SIMD*TW-1:0]      wdata,
  output logic                    wvalid,
  input  logic                    wready,
  output logic                    wlast
);

  localparam int DW = SIMD * TW;
  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
  logic [REP_BW-1:0]       reps_q, reps_d;
  logic [REP_BW-1:0]       pass_q, pass_d;
  logic                    pend_q, pend_last_q;
  logic                    zero_done_q;
  logic                    issue, drain_done, push, pop;

  logic [DW-1:0]           fifo_data_q [3];
  logic                    fifo_last_q [3];
  logic [1:0]              rd_ptr_q, wr_ptr_q, occ_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    reps_d     = reps_q;
    pass_d     = pass_q;
    issue      = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !zero_done_q && num_reps != '0) begin
          reps_d  = num_reps;
          addr_d  = '0;
          pass_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // A pop in this cycle is deliberately not credited, keeping the credit path short.
        if ((3'(occ_q) + 3'(pend_q)) < 3'd3) begin
          issue = 1'b1;
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            pass_d = pass_q + 1'b1;
            if (pass_q == reps_q - 1'b1) state_d = DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (occ_q == 2'd0 && !pend_q) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push = pend_q;
  assign pop  = wvalid && wready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      reps_q      <= '0;
      pass_q      <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      zero_done_q <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      reps_q      <= reps_d;
      pass_q      <= pass_d;
      pend_q      <= issue;
      pend_last_q <= issue && (addr_q == LAST_ADDR);
      zero_done_q <= (state_q == IDLE) && start && !zero_done_q && (num_reps == '0);
      if (push) wr_ptr_q <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; occupancy gates every read of it.
  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= wmem_in;
      fifo_last_q[wr_ptr_q] <= pend_last_q;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = drain_done || zero_done_q;
  assign wmem_addr = addr_q;
  assign wvalid    = (occ_q != 2'd0);
  assign wdata     = fifo_data_q[rd_ptr_q];
  assign wlast     = wvalid && fifo_last_q[rd_ptr_q];

endmodule
